i2c_master_seq: RTL and testbench
=================================

# i2c_master_seq

Single-byte I2C master sequencer that drives the shared open-drain SDA/SCL bus on behalf of one command port. Each accepted command produces one complete transaction: START, 7-bit address + R/W, one data byte written or read, then STOP. It is the bus-side counterpart of the team's `i2c_slave` and the block that exercises and configures slave devices in the design.

## Interface
- `CLK_DIV`, 250: `clock` cycles per quarter SCL period; minimum 4.
- `clock` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_addr` input 7: target slave address.
- `cmd_rw` input 1: 1 = read, 0 = write.
- `cmd_wdata` input 8: write byte, ignored for reads.
- `rsp_valid` output 1: one-cycle pulse marking transaction completion.
- `rsp_nack` output 1: valid with `rsp_valid`; 1 = address or write-data NACK.
- `rsp_rdata` output 8: read byte, valid with `rsp_valid`; 0 on write or NACK.
- `busy` output 1: high from command acceptance until `rsp_valid`.
- `SDA` inout 1: open-drain; driven 0 or released (z).
- `SCL` inout 1: open-drain; driven 0 or released (z).

## Operation
- Reset (`reset`=0): state IDLE, SDA/SCL released, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_nack`=0, `rsp_rdata`=0, counters cleared. Reset mid-transaction releases both lines on the next edge without generating a STOP.
- On acceptance, the block latches `cmd_addr`, `cmd_rw`, and `cmd_wdata`. Inputs are ignored thereafter until the block returns to IDLE.
- SDA and SCL are each passed through a 2-flop synchronizer before use.
- Each bit slot is 4 quarters (q0–q3), each quarter `CLK_DIV` cycles:
  - q0–q1: SCL held low; SDA updated at the start of q0.
  - q2–q3: SCL released.
  - SDA is sampled at the start of q3.
- States and transitions:
  - IDLE → START on accept.
  - START: q0–q1 both released; q2–q3 SDA low, SCL released.
  - START → ADDR: 8 bits, MSB first, `{cmd_addr, cmd_rw}`.
  - ADDR → ADDR_ACK: SDA released; sampled 1 → STOP with nack; sampled 0 → WR_DATA or RD_DATA.
  - WR_DATA: 8 bits MSB first → WR_ACK: sampled 1 sets nack. Either result → STOP.
  - RD_DATA: SDA released; 8 samples shifted in MSB first → RD_ACK: master drives NACK (SDA released) → STOP.
  - STOP: q0–q1 SCL low, SDA low; q2 SCL released; q3 SDA released → BUS_FREE.
  - BUS_FREE: 4 quarters idle, then pulse `rsp_valid` → IDLE.
- Bit counter is 3 bits and rolls 7→0 on the byte's last bit. Quarter counter is `$clog2(CLK_DIV)` bits.
- While driving a 1, the master releases SDA and does not check for arbitration loss (single-master bus).

## Timing
- Accept edge to first SDA fall: 2·`CLK_DIV` cycles plus 1 cycle.
- Full write or read: 84 quarters = 84·`CLK_DIV` cycles from accept to `rsp_valid`.
- Address NACK: 48 quarters.
- `cmd_ready` drops the cycle after acceptance and returns the cycle after `rsp_valid`. Back-to-back commands are therefore separated by at least one IDLE cycle.
- `rsp_valid` and `busy` falling occur in the same cycle; `rsp_nack` and `rsp_rdata` hold until the next acceptance.
- A `cmd_valid` arriving in the same cycle as `rsp_valid` is not accepted (`cmd_ready`=0 that cycle).

## Configuration
- `I2C_MASTER_STRETCH_EN` defined: in q2 of any slot, the quarter counter stalls while synchronized SCL reads 0. This supports slave clock stretching, and all latencies above grow by the stall time.
- Not defined: SCL readback is ignored and timing is strictly fixed.

## Structure
- Shared package `i2c_pkg`:
  - state encoding (IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP, BUS_FREE);
  - quarter-phase constants Q0–Q3;
  - ACK=0 / NACK=1 constants, shared with `i2c_slave`.
- One sub-module: `i2c_quarter_timer`, the `CLK_DIV` prescaler producing a quarter tick and 2-bit phase, with a `stall` input.

## Test plan
- Write `cmd_addr`=0x11, `cmd_wdata`=0xA5 against `i2c_slave` (address 0x11) → `rsp_valid` after 84·`CLK_DIV` cycles, `rsp_nack`=0; bus shows 0x22 then 0xA5.
- Read `cmd_addr`=0x11 → `rsp_rdata`=0x33, `rsp_nack`=0, master NACKs the data byte, STOP observed.
- Write to 0x22 (no device) → `rsp_nack`=1, `rsp_rdata`=0, `rsp_valid` at 48·`CLK_DIV` cycles, no data byte on the bus.
- Hold `cmd_valid` high continuously → exactly one accept per transaction, `cmd_ready` low throughout `busy`.
- Assert `reset`=0 during ADDR bit 3 → next edge SDA=z, SCL=z, `busy`=0, `cmd_ready`=1.
- With `I2C_MASTER_STRETCH_EN` defined, slave holds SCL low 100 cycles in data bit 2 → `rsp_valid` delayed by about 100 cycles and data still correct.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, quarter-phase names,
// ACK/NACK bus levels, and the latched master command record.
package i2c_pkg;

  // Master sequencer states
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START    = 4'd1;
  localparam logic [3:0] ST_ADDR     = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK = 4'd3;
  localparam logic [3:0] ST_WR_DATA  = 4'd4;
  localparam logic [3:0] ST_WR_ACK   = 4'd5;
  localparam logic [3:0] ST_RD_DATA  = 4'd6;
  localparam logic [3:0] ST_RD_ACK   = 4'd7;
  localparam logic [3:0] ST_STOP     = 4'd8;
  localparam logic [3:0] ST_BUS_FREE = 4'd9;

  // Quarter phases within one bit slot
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Acknowledge levels on SDA
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period prescaler: counts CLK_DIV cycles per quarter and steps a
// 2-bit phase. Held cleared while run is low; freezes while stall is high.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       stall,
  output logic       tick,
  output logic       q_first,
  output logic [1:0] phase
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] CNT_MAX = QW'(CLK_DIV - 1);

  logic [QW-1:0] cnt;

  assign tick    = run && !stall && (cnt == CNT_MAX);
  assign q_first = (cnt == '0);

  // Count cycles within a quarter, advance phase on wrap
  always_ff @(posedge clock) begin
    if (!reset || !run) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!stall) begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: START, addr+R/W, one data byte, STOP, bus-free gap.
// Optional: define I2C_MASTER_STRETCH_EN to let a slave stretch SCL (the
// quarter timer freezes in q2 while the synchronized SCL is still low).
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  inout  wire        SDA,
  inout  wire        SCL
);

  logic [3:0] state;
  logic [2:0] bit_cnt;
  i2c_cmd_t   cmd_q;
  logic [7:0] tx_sh, rx_sh;
  logic       nack_q;
  logic       sda_low, scl_low, sda_low_d, scl_low_d;
  logic [1:0] sda_sync;
  logic       tick, q_first, stall;
  logic [1:0] phase;
  logic       accept, slot_end, sample, sda_s;

  assign SDA = sda_low ? 1'b0 : 1'bz;
  assign SCL = scl_low ? 1'b0 : 1'bz;

  assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign slot_end  = tick && (phase == Q3);
  assign sample    = tick && (phase == Q2);   // start of q3
  assign sda_s     = sda_sync[1];

  // Two-flop SDA synchronizer; idle bus reads high
  always_ff @(posedge clock) begin
    if (!reset) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], SDA};
  end

`ifdef I2C_MASTER_STRETCH_EN
  logic [1:0] scl_sync;

  // Two-flop SCL synchronizer for clock-stretch detection
  always_ff @(posedge clock) begin
    if (!reset) scl_sync <= 2'b11;
    else        scl_sync <= {scl_sync[0], SCL};
  end

  assign stall = (phase == Q2) && !scl_sync[1];
`else
  assign stall = 1'b0;
`endif

  i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_qtmr (
    .clock   (clock),
    .reset   (reset),
    .run     (busy),
    .stall   (stall),
    .tick    (tick),
    .q_first (q_first),
    .phase   (phase)
  );

  // Transaction sequencing, shift registers and response capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      cmd_q     <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      nack_q    <= ACK;
      rsp_valid <= 1'b0;
      rsp_nack  <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          state     <= ST_START;
          cmd_q     <= '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
          bit_cnt   <= '0;
          nack_q    <= ACK;
          rsp_nack  <= 1'b0;
          rsp_rdata <= '0;
        end
        ST_START: if (slot_end) begin
          state <= ST_ADDR;
          tx_sh <= {cmd_q.addr, cmd_q.rw};
        end
        ST_ADDR, ST_WR_DATA: if (slot_end) begin
          tx_sh   <= {tx_sh[6:0], 1'b1};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
        end
        ST_ADDR_ACK: begin
          if (sample) nack_q <= sda_s;
          if (slot_end) begin
            if (nack_q == NACK) state <= ST_STOP;
            else if (cmd_q.rw)  state <= ST_RD_DATA;
            else begin
              state <= ST_WR_DATA;
              tx_sh <= cmd_q.wdata;
            end
          end
        end
        ST_WR_ACK: begin
          if (sample)   nack_q <= sda_s;
          if (slot_end) state  <= ST_STOP;
        end
        ST_RD_DATA: begin
          if (sample) rx_sh <= {rx_sh[6:0], sda_s};
          if (slot_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_RD_ACK;
          end
        end
        ST_RD_ACK:   if (slot_end) state <= ST_STOP;
        ST_STOP:     if (slot_end) state <= ST_BUS_FREE;
        ST_BUS_FREE: if (slot_end) begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_nack  <= nack_q;
          rsp_rdata <= (cmd_q.rw && nack_q == ACK) ? rx_sh : 8'h00;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Desired bus levels for the current state and quarter
  always_comb begin
    sda_low_d = 1'b0;
    scl_low_d = 1'b0;
    case (state)
      ST_START: sda_low_d = (phase >= Q2);
      ST_ADDR, ST_WR_DATA: begin
        scl_low_d = (phase <= Q1);
        sda_low_d = !tx_sh[7];
      end
      ST_ADDR_ACK, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK: scl_low_d = (phase <= Q1);
      ST_STOP: begin
        scl_low_d = (phase <= Q1);
        sda_low_d = (phase != Q3);
      end
      default: ;
    endcase
  end

  // Register line drivers; SDA waits one cycle into q0 so it never moves
  // on the same edge that SCL falls
  always_ff @(posedge clock) begin
    if (!reset) begin
      sda_low <= 1'b0;
      scl_low <= 1'b0;
    end else begin
      scl_low <= scl_low_d;
      if (!(busy && phase == Q0 && q_first)) sda_low <= sda_low_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: behavioural slave at 0x11 on a pulled-up bus,
// randomized commands checked against a transaction-level expectation.
module tb_i2c_master_seq;

  localparam int D = 8;
  localparam logic [6:0] SLV_ADDR = 7'h11;
`ifdef I2C_MASTER_STRETCH_EN
  localparam int STALL = 3;
`else
  localparam int STALL = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_rdata;
  wire        sda_w, scl_w;

  logic slv_sda_drv = 1'b0, slv_scl_drv = 1'b0;
  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = slv_sda_drv ? 1'b0 : 1'bz;
  assign scl_w = slv_scl_drv ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  i2c_master_seq #(.CLK_DIV(D)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
    .busy(busy), .SDA(sda_w), .SCL(scl_w)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake monitors
  int acc_n = 0, viol = 0;
  always @(posedge clock) if (cmd_valid && cmd_ready) acc_n <= acc_n + 1;
  always @(negedge clock) if (busy && cmd_ready) viol <= viol + 1;

  // Behavioural slave: ACKs its address and writes, serves slv_rdata on reads
  logic [7:0] slv_rdata = 8'h33;
  logic       stretch_req = 1'b0;
  logic       sda_p = 1'b1, scl_p = 1'b1, s_active = 1'b0;
  logic       s_sel = 1'b0, s_rd = 1'b0, m_ack = 1'b0;
  logic [7:0] s_sh = '0, s_addr_byte = '0, s_data_byte = '0;
  int s_bit = 0, s_frame = 0, frames = 0, stops = 0, start_cyc = 0, st_cnt = 0;

  always @(negedge clock) begin
    sda_p <= sda_w;
    scl_p <= scl_w;
    if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) slv_scl_drv <= 1'b0;
    end
    if (scl_w && scl_p && sda_p && !sda_w) begin
      s_active <= 1'b1; s_bit <= 0; s_frame <= 0;
      s_sel <= 1'b0; s_rd <= 1'b0; slv_sda_drv <= 1'b0; start_cyc <= cyc;
    end else if (scl_w && scl_p && !sda_p && sda_w) begin
      s_active <= 1'b0; slv_sda_drv <= 1'b0; stops <= stops + 1;
    end else if (s_active && scl_w && !scl_p) begin
      if (s_bit == 8) begin
        s_bit <= 0; s_frame <= s_frame + 1; frames <= frames + 1;
        if (s_frame == 1 && s_rd) m_ack <= sda_w;
      end else begin
        s_sh  <= {s_sh[6:0], sda_w};
        s_bit <= s_bit + 1;
      end
    end else if (s_active && !scl_w && scl_p) begin
      slv_sda_drv <= 1'b0;
      if (s_bit == 8 && s_frame == 0) begin
        s_addr_byte <= s_sh;
        s_sel       <= (s_sh[7:1] == SLV_ADDR);
        s_rd        <= s_sh[0];
        slv_sda_drv <= (s_sh[7:1] == SLV_ADDR);
      end else if (s_bit == 8 && s_frame == 1) begin
        s_data_byte <= s_sh;
        slv_sda_drv <= s_sel && !s_rd;
      end else if (s_frame == 1 && s_sel && s_rd && s_bit < 8) begin
        slv_sda_drv <= !slv_rdata[3'(7 - s_bit)];
      end
      if (stretch_req && s_frame == 1 && s_bit == 2) begin
        slv_scl_drv <= 1'b1;
        st_cnt      <= 100;
      end
    end
  end

  // One command, checked against the transaction-level expectation
  task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input bit stretched, input string tag);
    int t0, lat, f0, s0, exp_lat;
    logic got, exp_nack;
    logic [7:0] exp_rd;
    exp_nack = (a != SLV_ADDR);
    exp_rd   = (!exp_nack && rw) ? slv_rdata : 8'h00;
    exp_lat  = exp_nack ? 48 * D + 10 * STALL : 84 * D + 19 * STALL;
    f0 = frames; s0 = stops;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = wd;
    chk({tag, ".ready"}, cmd_ready, 1);
    t0 = cyc;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_addr = 7'($urandom); cmd_rw = 1'($urandom); cmd_wdata = 8'($urandom);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".nordy"}, cmd_ready, 0);
    got = 1'b0;
    for (int i = 0; i < 120 * D && !got; i++) begin
      @(negedge clock);
      if (rsp_valid) got = 1'b1;
    end
    chk({tag, ".rsp_seen"}, got, 1);
    if (got) begin
      lat = cyc - t0 - 1;
      if (stretched) chk({tag, ".lat_stretch"}, (lat - exp_lat >= 60 && lat - exp_lat <= 110), 1);
      else           chk({tag, ".lat"}, lat, exp_lat);
      chk({tag, ".start_lat"}, start_cyc - t0 - 1, 2 * D + 1);
      chk({tag, ".nack"}, rsp_nack, exp_nack);
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".busy_fall"}, busy, 0);
      chk({tag, ".rdy_low"}, cmd_ready, 0);
      chk({tag, ".addr_byte"}, s_addr_byte, {a, rw});
      chk({tag, ".frames"}, frames - f0, exp_nack ? 1 : 2);
      chk({tag, ".stop"}, stops - s0, 1);
      if (!exp_nack && !rw) chk({tag, ".wbyte"}, s_data_byte, wd);
      if (!exp_nack && rw)  chk({tag, ".mnack"}, m_ack, 1);
      @(negedge clock);
      chk({tag, ".rdy_back"}, cmd_ready, 1);
      chk({tag, ".nack_hold"}, rsp_nack, exp_nack);
      chk({tag, ".rdata_hold"}, rsp_rdata, exp_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ra;
    int n, a0, v0;
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.nack", rsp_nack, 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.sda", sda_w, 1);
    chk("rst.scl", scl_w, 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Directed: write, read, missing device
    run_cmd(7'h11, 1'b0, 8'hA5, 1'b0, "wr11");
    slv_rdata = 8'h33;
    run_cmd(7'h11, 1'b1, 8'h00, 1'b0, "rd11");
    run_cmd(7'h22, 1'b0, 8'h5A, 1'b0, "wr22");

    // Randomized commands
    for (int k = 0; k < 8; k++) begin
      ra = 7'($urandom);
      if (ra == SLV_ADDR) ra = ra ^ 7'h40;
      if ($urandom_range(0, 2) != 0) ra = SLV_ADDR;
      slv_rdata = 8'($urandom);
      run_cmd(ra, 1'($urandom), 8'($urandom), 1'b0, $sformatf("rnd%0d", k));
    end

    // cmd_valid held high across two transactions
    a0 = acc_n; v0 = viol; n = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = SLV_ADDR; cmd_rw = 1'b0; cmd_wdata = 8'($urandom);
    for (int i = 0; i < 300 * D && n < 2; i++) begin
      @(negedge clock);
      if (rsp_valid) n++;
    end
    cmd_valid = 1'b0;
    chk("hold.rsp", n, 2);
    chk("hold.accepts", acc_n - a0, 2);
    chk("hold.ready_busy", viol - v0, 0);
    repeat (2) @(negedge clock);

    // Reset in the middle of the address byte
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = SLV_ADDR; cmd_rw = 1'b0; cmd_wdata = 8'hFF;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (17 * D + D / 2) @(negedge clock);
    chk("mid.scl_low", scl_w, 0);
    chk("mid.sda_low", sda_w, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid.sda_rel", sda_w, 1);
    chk("mid.scl_rel", scl_w, 1);
    chk("mid.busy", busy, 0);
    chk("mid.ready", cmd_ready, 1);
    chk("mid.rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    run_cmd(7'h11, 1'b0, 8'h3C, 1'b0, "post_rst");

`ifdef I2C_MASTER_STRETCH_EN
    // Slave stretches SCL during data bit 2 of a read
    slv_rdata = 8'hC6;
    stretch_req = 1'b1;
    run_cmd(7'h11, 1'b1, 8'h00, 1'b1, "stretch");
    stretch_req = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
